volatility_engine: RTL and testbench
====================================

VOLATILITY_ENGINE -- requirements
Module: volatility_engine

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 32, price width.
- NUM_STOCKS, 4, independent channels.
- MAX_WINDOW_LOG2, 5, log2 of maximum window depth per stock.
- FRAC_BITS, 32, fractional bits of the variance output.
- FP_WORD_SIZE, 64, variance output width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- i_clk, in, 1, single clock.
- i_reset, in, 1, reset; asynchronous, active-high.
- i_valid, in, 1, sample offered.
- o_ready, out, 1, sample accepted when i_valid && o_ready.
- i_stock_id, in, $clog2(NUM_STOCKS), sample channel.
- i_best_ask, in, DATA_WIDTH, ask price.
- i_best_bid, in, DATA_WIDTH, bid price.
- i_clear, in, 1, clear/configure one channel.
- i_clear_stock_id, in, $clog2(NUM_STOCKS), channel to clear.
- i_window_log2, in, $clog2(MAX_WINDOW_LOG2+1), new window log2 L, where 1 <= L <= MAX_WINDOW_LOG2.
- o_valid, out, 1, result strobe.
- o_stock_id, out, $clog2(NUM_STOCKS), channel of result.
- o_curr_price, out, DATA_WIDTH, mid price of the sample.
- o_volatility, out, FP_WORD_SIZE, variance, unsigned, FRAC_BITS fractional bits.
- o_warm, out, 1, window for that stock is full.

Function
REQ-003 Mid price SHALL be (ask+bid)>>1 computed at DATA_WIDTH+1 bits, so there is no overflow wrap.
REQ-004 Each stock SHALL own a circular buffer of 2^MAX_WINDOW_LOG2 entries with an internal write pointer, fill count, running sum and running sum of squares. No external address is used.
REQ-005 Sum width SHALL be DATA_WIDTH+MAX_WINDOW_LOG2; sum-of-squares width SHALL be 2*DATA_WIDTH+MAX_WINDOW_LOG2. Arithmetic is exact with no truncation.
REQ-006 Window depth N SHALL be 2^L for that stock; the write pointer wraps modulo N.
REQ-007 On acceptance with count<N: add mid to sum, add mid^2 to sumsq, count+1.
REQ-008 On acceptance with count==N: subtract the evicted sample at the pointer (and its square) and add the new one in the same update.
REQ-009 Variance SHALL be ((N*sumsq - sum^2) << FRAC_BITS) >> 2L, using post-update sums.
REQ-010 The variance SHALL saturate to all-ones if it exceeds FP_WORD_SIZE bits.
REQ-011 o_warm SHALL be 1 iff post-update count==N. When o_warm=0, o_volatility SHALL be 0.
REQ-012 Pipeline latency SHALL be exactly 3 cycles from the acceptance edge to o_valid high. o_valid is a one-cycle strobe per accepted sample, carrying that sample's o_stock_id and o_curr_price.
REQ-013 Throughput SHALL be one sample per cycle for any stock sequence.
REQ-014 Back-to-back and every-other-cycle samples to the same stock SHALL produce results identical to widely spaced samples, via forwarding of in-flight sums, count, pointer and evicted value.
REQ-015 There is no output backpressure; the consumer always accepts o_valid.
REQ-016 o_ready SHALL be 0 only in a cycle where i_clear=1; otherwise it SHALL be 1.
REQ-017 On i_clear, in one cycle the target stock's sum, sumsq, count and pointer SHALL be zeroed and L latched. Buffer contents need not be cleared.
REQ-018 Samples already in flight for the cleared stock SHALL still emit their results, computed on pre-clear state.
REQ-019 i_valid and i_clear in the same cycle: the sample SHALL NOT be accepted (o_ready=0); the sender must hold it.
REQ-020 i_window_log2 outside 1..MAX_WINDOW_LOG2 SHALL be clamped into that range.
REQ-021 When idle, o_volatility, o_curr_price and o_stock_id SHALL hold their last values. Only o_valid is a strobe.

Reset
REQ-022 Asserting i_reset SHALL asynchronously force the following:
- o_valid=0, o_warm=0, o_volatility=0, o_curr_price=0, o_stock_id=0.
- All per-stock sums, counts and pointers = 0.
- All pipeline valid bits = 0; in-flight samples are discarded.
REQ-023 After reset every stock SHALL have L=MAX_WINDOW_LOG2.
REQ-024 o_ready SHALL be 0 while i_reset is high and 1 from the first clock edge after deassertion.

Verification
REQ-025 Warm-up and value:
- Stimulus: clear stock 1 with L=2, then mids 1,2,3,4 (ask=bid).
- Response: first three results have o_warm=0 and o_volatility=0; the fourth has o_warm=1 and o_volatility=0x1_4000_0000 (1.25).
REQ-026 Eviction:
- Stimulus: continue with mid 5.
- Response: window 2..5, o_volatility=0x1_4000_0000. Then mids 7,7,7,7 give 0 on the last.
REQ-027 Same-stock hazard:
- Stimulus: mids 10,20,30,40 to stock 0 (L=2) on consecutive cycles.
- Response: matches a gapped run; final o_volatility=125.0 (0x7D_0000_0000). Results appear on cycles t+3..t+6.
REQ-028 Overflow edge:
- Stimulus: ask=bid=0xFFFFFFFF.
- Response: o_curr_price=0xFFFFFFFF. With N=2 and identical samples, o_volatility=0 with no wrap.
REQ-029 Clear collision:
- Stimulus: i_valid and i_clear for stock 2 in the same cycle.
- Response: o_ready=0 and no result is emitted for that cycle's sample. An interleaved stock-3 stream keeps its sums.
REQ-030 Async reset:
- Stimulus: assert i_reset between clock edges with 3 samples in flight.
- Response: o_valid=0 immediately, no stale results appear after release, and the next sample reports o_warm=0.

Source files
------------

// File: rtl/volatility_engine.sv
// Per-stock rolling variance of the mid price over a power-of-two window.
// Running sums are read, updated and written back in one stage, so same-stock streams never see stale state.
module volatility_engine #(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_STOCKS      = 4,
   parameter int MAX_WINDOW_LOG2 = 5,
   parameter int FRAC_BITS       = 32,
   parameter int FP_WORD_SIZE    = 64
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  logic [$clog2(NUM_STOCKS)-1:0]          i_stock_id,
   input  logic [DATA_WIDTH-1:0]                  i_best_ask,
   input  logic [DATA_WIDTH-1:0]                  i_best_bid,
   input  logic                                   i_clear,
   input  logic [$clog2(NUM_STOCKS)-1:0]          i_clear_stock_id,
   input  logic [$clog2(MAX_WINDOW_LOG2+1)-1:0]   i_window_log2,
   output logic                                   o_valid,
   output logic [$clog2(NUM_STOCKS)-1:0]          o_stock_id,
   output logic [DATA_WIDTH-1:0]                  o_curr_price,
   output logic [FP_WORD_SIZE-1:0]                o_volatility,
   output logic                                   o_warm
);
   localparam int SW     = $clog2(NUM_STOCKS);
   localparam int LW     = $clog2(MAX_WINDOW_LOG2+1);
   localparam int ML     = MAX_WINDOW_LOG2;
   localparam int DEPTH  = 1 << ML;
   localparam int CW     = ML + 1;
   localparam int SUM_W  = DATA_WIDTH + ML;
   localparam int SQ_W   = 2*DATA_WIDTH + ML;
   localparam int DIFF_W = SQ_W + ML;
   localparam int SH_W   = DIFF_W + FRAC_BITS;

   logic                  ready_q;
   logic                  accept;
   logic [DATA_WIDTH:0]   mid_full;
   logic [DATA_WIDTH-1:0] mid;
   logic [LW-1:0]         l_new;

   logic [SUM_W-1:0]      sum_q [NUM_STOCKS];
   logic [SQ_W-1:0]       sq_q  [NUM_STOCKS];
   logic [CW-1:0]         cnt_q [NUM_STOCKS];
   logic [ML-1:0]         ptr_q [NUM_STOCKS];
   logic [LW-1:0]         l_q   [NUM_STOCKS];
   logic [DATA_WIDTH-1:0] buf_mem [NUM_STOCKS][DEPTH];

   logic                  a_valid;
   logic [SW-1:0]         a_id;
   logic [DATA_WIDTH-1:0] a_mid;
   logic [LW-1:0]         a_l;
   logic [CW-1:0]         a_n, a_cnt, a_cnt_new;
   logic [ML-1:0]         a_ptr, a_ptr_new;
   logic                  a_full;
   logic [DATA_WIDTH-1:0] a_evict;
   logic [SQ_W-1:0]       a_msq, a_esq, a_sq_new;
   logic [SUM_W-1:0]      a_sum_new;

   logic                  b_valid, b_warm;
   logic [SW-1:0]         b_id;
   logic [DATA_WIDTH-1:0] b_mid;
   logic [SUM_W-1:0]      b_sum;
   logic [SQ_W-1:0]       b_sq;
   logic [LW-1:0]         b_l;
   logic [DIFF_W-1:0]     b_nsq, b_ssq;

   logic                  c_valid, c_warm;
   logic [SW-1:0]         c_id;
   logic [DATA_WIDTH-1:0] c_mid;
   logic [LW-1:0]         c_l;
   logic [DIFF_W-1:0]     c_diff;
   logic [SH_W-1:0]       c_shift;
   logic [FP_WORD_SIZE-1:0] c_vol;

   assign o_ready  = ready_q & ~i_clear;
   assign accept   = i_valid & o_ready;
   assign mid_full = {1'b0, i_best_ask} + {1'b0, i_best_bid};
   assign mid      = DATA_WIDTH'(mid_full >> 1);

   always_comb begin
      if (i_window_log2 == '0)
         l_new = LW'(1);
      else if (i_window_log2 > LW'(ML))
         l_new = LW'(ML);
      else
         l_new = i_window_log2;
   end

   // Eviction only once the window is full; the evicted slot is the one about to be overwritten.
   always_comb begin
      a_l       = l_q[a_id];
      a_n       = CW'(1) << a_l;
      a_cnt     = cnt_q[a_id];
      a_ptr     = ptr_q[a_id];
      a_full    = (a_cnt == a_n);
      a_evict   = a_full ? buf_mem[a_id][a_ptr] : '0;
      a_msq     = SQ_W'(a_mid) * SQ_W'(a_mid);
      a_esq     = SQ_W'(a_evict) * SQ_W'(a_evict);
      a_sum_new = sum_q[a_id] + SUM_W'(a_mid) - SUM_W'(a_evict);
      a_sq_new  = sq_q[a_id] + a_msq - a_esq;
      a_cnt_new = a_full ? a_cnt : a_cnt + CW'(1);
      a_ptr_new = ML'((CW'(a_ptr) + CW'(1)) & (a_n - CW'(1)));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ready_q <= 1'b0;
         a_valid <= 1'b0;
         a_id    <= '0;
         a_mid   <= '0;
         for (int s = 0; s < NUM_STOCKS; s++) begin
            sum_q[s] <= '0;
            sq_q[s]  <= '0;
            cnt_q[s] <= '0;
            ptr_q[s] <= '0;
            l_q[s]   <= LW'(ML);
         end
      end else begin
         ready_q <= 1'b1;
         a_valid <= accept;
         if (accept) begin
            a_id  <= i_stock_id;
            a_mid <= mid;
         end
         // A clear landing on the same edge as an update wins; the in-flight result still leaves on old state.
         for (int s = 0; s < NUM_STOCKS; s++) begin
            if (i_clear && i_clear_stock_id == SW'(s)) begin
               sum_q[s] <= '0;
               sq_q[s]  <= '0;
               cnt_q[s] <= '0;
               ptr_q[s] <= '0;
               l_q[s]   <= l_new;
            end else if (a_valid && a_id == SW'(s)) begin
               sum_q[s] <= a_sum_new;
               sq_q[s]  <= a_sq_new;
               cnt_q[s] <= a_cnt_new;
               ptr_q[s] <= a_ptr_new;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (a_valid)
         buf_mem[a_id][a_ptr] <= a_mid;
   end

   assign b_nsq = DIFF_W'(b_sq) << b_l;
   assign b_ssq = DIFF_W'(b_sum) * DIFF_W'(b_sum);

   assign c_shift = {c_diff, {FRAC_BITS{1'b0}}} >> {c_l, 1'b0};
   assign c_vol   = ((c_shift >> FP_WORD_SIZE) != '0) ? '1 : FP_WORD_SIZE'(c_shift);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         b_valid      <= 1'b0;
         b_warm       <= 1'b0;
         b_id         <= '0;
         b_mid        <= '0;
         b_sum        <= '0;
         b_sq         <= '0;
         b_l          <= '0;
         c_valid      <= 1'b0;
         c_warm       <= 1'b0;
         c_id         <= '0;
         c_mid        <= '0;
         c_l          <= '0;
         c_diff       <= '0;
         o_valid      <= 1'b0;
         o_stock_id   <= '0;
         o_curr_price <= '0;
         o_volatility <= '0;
         o_warm       <= 1'b0;
      end else begin
         b_valid <= a_valid;
         b_id    <= a_id;
         b_mid   <= a_mid;
         b_sum   <= a_sum_new;
         b_sq    <= a_sq_new;
         b_warm  <= (a_cnt_new == a_n);
         b_l     <= a_l;

         c_valid <= b_valid;
         c_id    <= b_id;
         c_mid   <= b_mid;
         c_warm  <= b_warm;
         c_l     <= b_l;
         c_diff  <= b_warm ? (b_nsq - b_ssq) : '0;

         o_valid <= c_valid;
         if (c_valid) begin
            o_stock_id   <= c_id;
            o_curr_price <= c_mid;
            o_volatility <= c_vol;
            o_warm       <= c_warm;
         end
      end
   end
endmodule

// File: tb/tb_volatility_engine.sv
// Bench for volatility_engine: constant vector table, hand-written corner sequences,
// then random traffic checked against a queue-based window model.
module tb_volatility_engine;
   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [1:0]  i_stock_id = '0;
   logic [31:0] i_best_ask = '0;
   logic [31:0] i_best_bid = '0;
   logic        i_clear = 1'b0;
   logic [1:0]  i_clear_stock_id = '0;
   logic [2:0]  i_window_log2 = '0;
   logic        o_valid;
   logic [1:0]  o_stock_id;
   logic [31:0] o_curr_price;
   logic [63:0] o_volatility;
   logic        o_warm;

   volatility_engine dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_stock_id(i_stock_id), .i_best_ask(i_best_ask), .i_best_bid(i_best_bid),
      .i_clear(i_clear), .i_clear_stock_id(i_clear_stock_id), .i_window_log2(i_window_log2),
      .o_valid(o_valid), .o_stock_id(o_stock_id), .o_curr_price(o_curr_price),
      .o_volatility(o_volatility), .o_warm(o_warm)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int          id;
      logic [31:0] price;
      logic [63:0] vol;
      logic        warm;
      int          due;
   } exp_t;

   typedef struct {
      logic        clr;
      int          cid;
      int          wl;
      int          id;
      logic [31:0] ask;
      logic [31:0] bid;
      logic        warm;
      logic [63:0] vol;
      logic [31:0] price;
   } vec_t;

   exp_t        exp_q[$];
   logic [31:0] mq[4][$];
   int          ml[4];

   logic [1:0]  last_id;
   logic [31:0] last_price;
   logic [63:0] last_vol;
   logic        last_warm;

   function automatic void check(string name, logic [127:0] act, logic [127:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   function automatic vec_t mk(logic clr, int cid, int wl, int id, logic [31:0] ask,
                               logic [31:0] bid, logic w, logic [63:0] v, logic [31:0] p);
      vec_t r;
      r.clr = clr; r.cid = cid; r.wl = wl; r.id = id; r.ask = ask; r.bid = bid;
      r.warm = w; r.vol = v; r.price = p;
      return r;
   endfunction

   // Window model: keep the last N mids literally and compute the variance from scratch.
   function automatic void model_accept(int id, logic [31:0] mid, int due);
      exp_t         e;
      int           nn;
      logic [127:0] s, sq, x, diff, sh;
      nn = 1 << ml[id];
      mq[id].push_back(mid);
      while (mq[id].size() > nn) void'(mq[id].pop_front());
      s = '0;
      sq = '0;
      for (int k = 0; k < mq[id].size(); k++) begin
         x = 128'(mq[id][k]);
         s += x;
         sq += x * x;
      end
      e.id = id;
      e.price = mid;
      e.due = due;
      e.warm = (mq[id].size() == nn);
      diff = 128'(nn) * sq - s * s;
      sh = (diff << 32) >> (2 * ml[id]);
      if (!e.warm)
         e.vol = '0;
      else if ((sh >> 64) != 0)
         e.vol = '1;
      else
         e.vol = sh[63:0];
      exp_q.push_back(e);
   endfunction

   function automatic void model_clear(int id, int wl);
      mq[id].delete();
      ml[id] = (wl < 1) ? 1 : (wl > 5) ? 5 : wl;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      for (int s = 0; s < 4; s++) begin
         mq[s].delete();
         ml[s] = 5;
      end
      last_id = '0;
      last_price = '0;
      last_vol = '0;
      last_warm = 1'b0;
   endfunction

   always @(negedge i_clk) begin : mon
      exp_t e;
      if (!i_reset) begin
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", o_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("latency", cyc, e.due);
               check("stock_id", o_stock_id, e.id);
               check("curr_price", o_curr_price, e.price);
               check("warm", o_warm, e.warm);
               check("volatility", o_volatility, e.vol);
            end
            last_id = o_stock_id;
            last_price = o_curr_price;
            last_vol = o_volatility;
            last_warm = o_warm;
         end else begin
            check("idle_hold", {o_stock_id, o_curr_price, o_volatility, o_warm},
                  {last_id, last_price, last_vol, last_warm});
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               check("missing_result", o_valid, 1'b1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus, starting and ending on a falling edge.
   task automatic drive(input logic v, input int id, input logic [31:0] ask, input logic [31:0] bid,
                        input logic clr, input int cid, input int wl);
      logic [32:0] t;
      i_valid = v;
      i_stock_id = 2'(id);
      i_best_ask = ask;
      i_best_bid = bid;
      i_clear = clr;
      i_clear_stock_id = 2'(cid);
      i_window_log2 = 3'(wl);
      #1;
      check("o_ready", o_ready, !clr);
      if (v && !clr) begin
         t = {1'b0, ask} + {1'b0, bid};
         model_accept(id, t[32:1], cyc + 4);
      end
      if (clr) model_clear(cid, wl);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic sample(input int id, input logic [31:0] m);
      drive(1'b1, id, m, m, 1'b0, 0, 0);
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      i_clear = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic wait_result(output logic found, output logic [63:0] vol, output logic warm,
                              output logic [31:0] price);
      found = 1'b0;
      vol = '0;
      warm = 1'b0;
      price = '0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (o_valid) begin
            found = 1'b1;
            vol = o_volatility;
            warm = o_warm;
            price = o_curr_price;
         end else begin
            @(negedge i_clk);
         end
      end
      if (!found) check("result_timeout", o_valid, 1'b1);
   endtask

   initial begin
      vec_t        tbl[$];
      logic        found, w;
      logic [63:0] v;
      logic [31:0] p;
      int          nres;
      logic [63:0] lastv;
      int          r;
      logic [31:0] ask, bid;

      model_reset();

      tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 64'h0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 2, 2, 0, 64'h0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 4, 2, 0, 64'h0, 3));
      tbl.push_back(mk(0, 0, 0, 1, 4, 4, 1, 64'h1_4000_0000, 4));
      tbl.push_back(mk(0, 0, 0, 1, 5, 5, 1, 64'h1_4000_0000, 5));
      tbl.push_back(mk(0, 0, 0, 1, 7, 7, 1, 64'h2_3000_0000, 7));
      tbl.push_back(mk(0, 0, 0, 1, 8, 6, 1, 64'h1_B000_0000, 7));
      tbl.push_back(mk(0, 0, 0, 1, 7, 7, 1, 64'h0_C000_0000, 7));
      tbl.push_back(mk(0, 0, 0, 1, 7, 7, 1, 64'h0, 7));
      tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'h0, 32'hFFFF_FFFF));
      tbl.push_back(mk(0, 0, 0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h0, 32'hFFFF_FFFF));
      tbl.push_back(mk(0, 0, 0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 64'h4000_0000, 32'hFFFF_FFFE));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 3, 4, 4, 0, 64'h0, 4));
      tbl.push_back(mk(0, 0, 0, 3, 6, 6, 1, 64'h1_0000_0000, 6));
      tbl.push_back(mk(1, 3, 7, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 3, 9, 9, 0, 64'h0, 9));

      // Power-on reset and release between edges.
      #12;
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_outputs", {o_stock_id, o_curr_price, o_volatility, o_warm}, '0);
      check("rst_o_ready", o_ready, 1'b0);
      i_reset = 1'b0;
      #1 check("ready_before_edge", o_ready, 1'b0);
      #3 check("ready_after_edge", o_ready, 1'b1);
      @(negedge i_clk);

      foreach (tbl[i]) begin
         if (tbl[i].clr) begin
            drive(1'b0, 0, 0, 0, 1'b1, tbl[i].cid, tbl[i].wl);
         end else begin
            drive(1'b1, tbl[i].id, tbl[i].ask, tbl[i].bid, 1'b0, 0, 0);
            wait_result(found, v, w, p);
            if (found) begin
               check($sformatf("tbl%0d_warm", i), w, tbl[i].warm);
               check($sformatf("tbl%0d_vol", i), v, tbl[i].vol);
               check($sformatf("tbl%0d_price", i), p, tbl[i].price);
            end
         end
      end
      idle(4);

      // Same-stock back-to-back stream.
      drive(1'b0, 0, 0, 0, 1'b1, 0, 2);
      sample(0, 10); sample(0, 20); sample(0, 30); sample(0, 40);
      nres = 0;
      lastv = '0;
      for (int k = 0; k < 10; k++) begin
         if (o_valid) begin
            nres++;
            lastv = o_volatility;
         end
         @(negedge i_clk);
      end
      check("b2b_count", nres, 4);
      check("b2b_final_vol", lastv, 64'h7D_0000_0000);

      // Every-other-cycle stream to the same stock.
      drive(1'b0, 0, 0, 0, 1'b1, 0, 2);
      sample(0, 10); idle(1); sample(0, 20); idle(1); sample(0, 30); idle(1); sample(0, 40);
      idle(6);

      // Clear collision with an interleaved stock-3 stream, plus clear of a stock with a sample in flight.
      drive(1'b0, 0, 0, 0, 1'b1, 3, 3);
      sample(3, 100);
      drive(1'b1, 2, 55, 55, 1'b1, 2, 1);
      sample(3, 110);
      sample(2, 77);
      drive(1'b0, 0, 0, 0, 1'b1, 2, 1);
      sample(3, 120); sample(2, 5); sample(3, 130); sample(2, 9); sample(3, 140);
      idle(6);

      // Asynchronous reset with three samples in flight.
      for (int k = 0; k < 5; k++) sample(0, 32'(200 + k));
      #2;
      check("pre_reset_valid", o_valid, 1'b1);
      i_reset = 1'b1;
      model_reset();
      #1;
      check("async_rst_valid", o_valid, 1'b0);
      check("async_rst_outputs", {o_stock_id, o_curr_price, o_volatility, o_warm}, '0);
      check("async_rst_ready", o_ready, 1'b0);
      repeat (2) @(negedge i_clk);
      #2 i_reset = 1'b0;
      @(negedge i_clk);
      sample(0, 3);
      wait_result(found, v, w, p);
      if (found) check("post_reset_warm", w, 1'b0);
      idle(8);

      // Random traffic.
      for (int s = 0; s < 4; s++) drive(1'b0, 0, 0, 0, 1'b1, s, $urandom_range(1, 3));
      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) begin
            ask = $urandom;
            bid = $urandom;
         end else begin
            ask = $urandom_range(0, 300);
            bid = $urandom_range(0, 300);
         end
         if (r < 3)
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3), ask, bid, 1'b1,
                  $urandom_range(0, 3), $urandom_range(0, 7));
         else if (r < 75)
            drive(1'b1, $urandom_range(0, 3), ask, bid, 1'b0, 0, 0);
         else
            idle(1);
      end
      idle(10);
      check("drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
